// File: rtl/prio_arbiter_pkg.sv
// Shared types and helpers for the prio_arbiter slice.
// The arbiter FSM state and the hold-counter width helper live here.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // Width that can hold every value 0..max_hold without wrapping.
  function automatic int hold_cnt_width(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between 2**N requesters and prio_arbiter.
// The master side drives requests and done; the slave (arbiter) drives the grant.
interface prio_arbiter_if #(
  parameter int N = 2
) ();
  logic [2**N-1:0] req;
  logic            done;
  logic            gnt_valid;
  logic [N-1:0]    gnt_idx;
  logic [2**N-1:0] gnt_onehot;
  logic            timeout;

  modport master (
    output req, done,
    input  gnt_valid, gnt_idx, gnt_onehot, timeout
  );

  modport slave (
    input  req, done,
    output gnt_valid, gnt_idx, gnt_onehot, timeout
  );
endinterface

// File: rtl/prio_arbiter_pick.sv
// prio_pick: combinational masked search over a request vector from a start index.
// DESCEND=1 scans start, start-1, ... with wrap; DESCEND=0 scans upward with wrap.
module prio_pick #(
  parameter int N       = 2,
  parameter bit DESCEND = 1'b0
) (
  input  logic [2**N-1:0] i_req,
  input  logic [N-1:0]    i_start,
  output logic            o_found,
  output logic [N-1:0]    o_idx
);
  localparam int W = 2**N;

  logic [W-1:0] w_rot;
  logic [N-1:0] w_off;

  // w_rot[k] is the request seen k steps away from the start in scan order.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_rot
      logic [N-1:0] w_pos;
      if (DESCEND) begin : g_dn
        assign w_pos = i_start - N'(gi);
      end else begin : g_up
        assign w_pos = i_start + N'(gi);
      end
      assign w_rot[gi] = i_req[w_pos];
    end
  endgenerate

  always_comb begin
    w_off = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = N'(i);
    end
  end

  assign o_found = |i_req;
  assign o_idx   = DESCEND ? (i_start - w_off) : (i_start + w_off);

endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter: registered 2**N-way arbiter with a per-grant hold limit of MAX_HOLD cycles.
// Define ARB_RR_EN for round-robin selection; otherwise the highest requesting index wins.
module prio_arbiter #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 8
) (
  input logic           clk,
  input logic           reset,
  prio_arbiter_if.slave bus
);
  import arb_pkg::*;

  localparam int              W         = 2**N;
  localparam int              HW        = hold_cnt_width(MAX_HOLD);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t      r_state;
  logic            r_gnt_valid;
  logic [N-1:0]    r_gnt_idx;
  logic [W-1:0]    r_gnt_onehot;
  logic            r_timeout;
  logic [HW-1:0]   r_hold_cnt;

  logic            w_found;
  logic [N-1:0]    w_win;
  logic [N-1:0]    w_start;
  logic            w_release_normal;
  logic            w_expired;

`ifdef ARB_RR_EN
  logic [N-1:0] r_ptr;

  // Search begins one past the previous owner so every requester gets a turn.
  assign w_start = r_ptr + N'(1);

  prio_pick #(.N(N), .DESCEND(1'b0)) u_pick (
    .i_req   (bus.req),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '1;
    end else if (r_state == ARB_IDLE && w_found) begin
      r_ptr <= w_win;
    end
  end
`else
  assign w_start = '1;

  prio_pick #(.N(N), .DESCEND(1'b1)) u_pick (
    .i_req   (bus.req),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_win)
  );
`endif

  // A normal release outranks expiry, so a coinciding done/drop never pulses timeout.
  assign w_release_normal = bus.done || !bus.req[r_gnt_idx];
  assign w_expired        = (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_gnt_valid  <= 1'b0;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
      r_timeout    <= 1'b0;
      r_hold_cnt   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_timeout <= 1'b0;
          if (w_found) begin
            r_state      <= ARB_GRANT;
            r_gnt_valid  <= 1'b1;
            r_gnt_idx    <= w_win;
            r_gnt_onehot <= W'(1) << w_win;
            r_hold_cnt   <= '0;
          end
        end
        ARB_GRANT: begin
          if (w_release_normal || w_expired) begin
            r_state      <= ARB_IDLE;
            r_gnt_valid  <= 1'b0;
            r_gnt_idx    <= '0;
            r_gnt_onehot <= '0;
            r_timeout    <= !w_release_normal;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.gnt_valid  = r_gnt_valid;
  assign bus.gnt_idx    = r_gnt_idx;
  assign bus.gnt_onehot = r_gnt_onehot;
  assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter (N=2, MAX_HOLD=4): directed scenarios plus random traffic,
// every cycle compared against a behavioural model; works with or without ARB_RR_EN.
module tb_prio_arbiter;
  localparam int N        = 2;
  localparam int W        = 4;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic tb_reset;

  prio_arbiter_if #(.N(N)) bus ();

  prio_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (tb_reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what the outputs must be after the most recent edge.
  bit m_valid;
  int m_idx;
  int m_held;
  int m_ptr;
  bit m_timeout;

  function automatic int pick(input logic [W-1:0] rq);
`ifdef ARB_RR_EN
    for (int k = 1; k <= W; k++) begin
      int c;
      c = (m_ptr + k) % W;
      if (rq[c]) return c;
    end
`else
    for (int c = W - 1; c >= 0; c--) begin
      if (rq[c]) return c;
    end
`endif
    return 0;
  endfunction

  task automatic model_step();
    logic [W-1:0] rq;
    rq = bus.req;
    if (tb_reset) begin
      m_valid = 0; m_idx = 0; m_held = 0; m_timeout = 0; m_ptr = W - 1;
    end else if (m_valid) begin
      m_held++;
      if (bus.done || !rq[m_idx]) begin
        m_valid = 0; m_idx = 0; m_timeout = 0;
      end else if (m_held == MAX_HOLD) begin
        m_valid = 0; m_idx = 0; m_timeout = 1;
      end
    end else begin
      m_timeout = 0;
      if (rq != '0) begin
        m_idx = pick(rq); m_valid = 1; m_held = 0; m_ptr = m_idx;
      end
    end
  endtask

  task automatic compare_model();
    logic [7:0] act, exp;
    logic [W-1:0] oh;
    oh  = m_valid ? (4'b0001 << m_idx) : 4'b0000;
    act = {bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout};
    exp = {m_valid, N'(m_idx), oh, m_timeout};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t actual v=%b idx=%0d oh=%b to=%b required v=%b idx=%0d oh=%b to=%b",
               $time, act[7], act[6:5], act[4:1], act[0], exp[7], exp[6:5], exp[4:1], exp[0]);
    end
  endtask

  task automatic check_out(input string name, input logic v, input logic [N-1:0] idx,
                           input logic [W-1:0] oh, input logic to);
    logic [7:0] act, exp;
    act = {bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout};
    exp = {v, idx, oh, to};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual v=%b idx=%0d oh=%b to=%b required v=%b idx=%0d oh=%b to=%b",
               name, act[7], act[6:5], act[4:1], act[0], v, idx, oh, to);
    end
  endtask

  task automatic cyc(input logic [W-1:0] rq, input logic dn, input logic rst);
    bus.req  = rq;
    bus.done = dn;
    tb_reset = rst;
    @(posedge clk);
    model_step();
    @(negedge clk);
    $display("[TB] t=%0t req=%b done=%b rst=%b -> v=%b idx=%0d oh=%b to=%b",
             $time, rq, dn, rst, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout);
    compare_model();
  endtask

  logic [N-1:0] exp_seq [5];
  logic [W-1:0] r_rq;
  logic         r_dn, r_rst;

  initial begin
    bus.req  = '0;
    bus.done = 1'b0;
    tb_reset = 1'b1;

    // Reset held two cycles with every request asserted.
    cyc(4'b1111, 1'b0, 1'b1); check_out("reset_c1", 1'b0, 2'd0, 4'b0000, 1'b0);
    cyc(4'b1111, 1'b0, 1'b1); check_out("reset_c2", 1'b0, 2'd0, 4'b0000, 1'b0);

    // done release with req=0110.
    cyc(4'b0110, 1'b0, 1'b0);
`ifdef ARB_RR_EN
    check_out("rr_first_grant", 1'b1, 2'd1, 4'b0010, 1'b0);
`else
    check_out("fix_c1_grant", 1'b1, 2'd2, 4'b0100, 1'b0);
`endif
    cyc(4'b0110, 1'b0, 1'b0);
    cyc(4'b0110, 1'b1, 1'b0); check_out("done_c3_idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    cyc(4'b0110, 1'b0, 1'b0); check_out("done_c4_regrant", 1'b1, 2'd2, 4'b0100, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // Hold expiry with req=1000 held.
    for (int c = 1; c <= 4; c++) begin
      cyc(4'b1000, 1'b0, 1'b0);
      check_out("timeout_hold", 1'b1, 2'd3, 4'b1000, 1'b0);
    end
    cyc(4'b1000, 1'b0, 1'b0); check_out("timeout_pulse", 1'b0, 2'd0, 4'b0000, 1'b1);
    cyc(4'b1000, 1'b0, 1'b0); check_out("timeout_regrant", 1'b1, 2'd3, 4'b1000, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0); check_out("timeout_drop", 1'b0, 2'd0, 4'b0000, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // Dropped request in grant cycle 2.
    cyc(4'b0010, 1'b0, 1'b0); check_out("drop_grant", 1'b1, 2'd1, 4'b0010, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0); check_out("drop_release", 1'b0, 2'd0, 4'b0000, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // done coinciding with hold expiry: normal release, no timeout.
    for (int c = 1; c <= 4; c++) cyc(4'b0010, 1'b0, 1'b0);
    cyc(4'b0010, 1'b1, 1'b0); check_out("done_at_expiry", 1'b0, 2'd0, 4'b0000, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // Dropped request coinciding with hold expiry.
    for (int c = 1; c <= 4; c++) cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0); check_out("drop_at_expiry", 1'b0, 2'd0, 4'b0000, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);

    // All four requesting, done pulsed in every grant cycle.
`ifdef ARB_RR_EN
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    exp_seq = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
    cyc(4'b1111, 1'b0, 1'b1);
    cyc(4'b1111, 1'b0, 1'b0);
    check_out("seq_grant0", 1'b1, exp_seq[0], 4'b0001 << exp_seq[0], 1'b0);
    for (int k = 1; k < 5; k++) begin
      cyc(4'b1111, 1'b1, 1'b0); check_out("seq_bubble", 1'b0, 2'd0, 4'b0000, 1'b0);
      cyc(4'b1111, 1'b0, 1'b0);
      check_out("seq_grant", 1'b1, exp_seq[k], 4'b0001 << exp_seq[k], 1'b0);
    end
    cyc(4'b1111, 1'b1, 1'b0);

    // Reset mid-grant, then all requesting.
    cyc(4'b0100, 1'b0, 1'b0); check_out("mid_grant", 1'b1, 2'd2, 4'b0100, 1'b0);
    cyc(4'b1111, 1'b0, 1'b1); check_out("mid_reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0);
`ifdef ARB_RR_EN
    check_out("after_reset_grant", 1'b1, 2'd0, 4'b0001, 1'b0);
`else
    check_out("after_reset_grant", 1'b1, 2'd3, 4'b1000, 1'b0);
`endif
    cyc(4'b0000, 1'b1, 1'b0);

    // Random traffic; the owner's line is usually kept high so expiries occur.
    for (int i = 0; i < 400; i++) begin
      r_rq  = 4'($urandom_range(15));
      if (m_valid && $urandom_range(3) != 0) r_rq = r_rq | (4'b0001 << m_idx);
      r_dn  = ($urandom_range(5) == 0);
      r_rst = ($urandom_range(99) == 0);
      cyc(r_rq, r_dn, r_rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Registered, parametrised successor to the combinational 2^n-to-n priority encoder. It arbitrates 2**N request lines and holds a grant for the winning requester until that requester releases it or a hold limit expires. The grant is returned as both an index and a one-hot vector. It sits between 2**N requesters and one shared resource, and supports fixed-priority or round-robin selection.

## Interface
- N, default 2: log2 of the requester count (2**N requesters); N >= 1.
- MAX_HOLD, default 8: maximum number of consecutive cycles one grant may be held; MAX_HOLD >= 1.
- clk  input  1  the single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2**N  request lines; bit i belongs to requester i.
- done  input  1  current owner releases its grant; ignored while no grant is active.
- gnt_valid  output  1  a grant is active.
- gnt_idx  output  N  index of the owner; 0 when gnt_valid=0.
- gnt_onehot  output  2**N  one-hot owner vector; all zeros when gnt_valid=0.
- timeout  output  1  one-cycle pulse marking a forced release due to hold expiry.

## Operation
- Two-state FSM:
  - IDLE: if req != 0, register the winner and go to GRANT. Otherwise stay in IDLE.
  - GRANT: stay while req[owner]=1, done=0 and hold_cnt < MAX_HOLD-1. Otherwise go to IDLE.
- Release causes (priority order):
  - done=1: normal release.
  - req[owner]=0: normal release.
  - hold_cnt == MAX_HOLD-1: forced release; timeout=1 in the following cycle.
- If done or a dropped request coincides with hold expiry, the release counts as normal and timeout stays 0.
- After any release, the FSM spends exactly one cycle in IDLE (a bubble) before the next grant.
- hold_cnt:
  - Width $clog2(MAX_HOLD+1).
  - Cleared on entry to GRANT; increments each GRANT cycle; never wraps.
- Winner selection, fixed mode: the highest set index in req wins (same priority order as the original encoder).
- Winner selection, round-robin mode:
  - Search upward from (ptr+1) mod 2**N with wrap-around; the first set bit wins.
  - ptr updates to the owner index on each grant.
- req is sampled only in IDLE. Changes on non-owner lines during GRANT have no effect.
- Reset values: state IDLE, gnt_valid 0, gnt_idx 0, gnt_onehot 0, timeout 0, hold_cnt 0, ptr 2**N-1 (so the first round-robin search starts at 0).
- Reset asserted mid-grant takes effect at the next edge with the values above; the grant is dropped and timeout is not pulsed.

## Timing
- Latency: a request visible in IDLE at edge k produces gnt_valid=1 after edge k (one cycle).
- All outputs are registered; no combinational path from inputs to outputs.
- A grant lasts 1..MAX_HOLD cycles.
- Release: done or a dropped req sampled at edge k gives gnt_valid=0 after edge k.
- Minimum gap between two grants is one cycle.
- timeout is high for exactly one cycle, the first IDLE cycle after a forced release.
- gnt_idx and gnt_onehot change only together with gnt_valid transitions.

## Configuration
- ARB_RR_EN defined: round-robin selection, with the ptr register compiled in.
- ARB_RR_EN undefined: fixed highest-index-wins selection; no ptr register exists.
- All other behaviour is identical in both builds.

## Structure
- Package arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  - a localparam function for the hold-counter width.
- Sub-module prio_pick: a combinational masked search. Inputs are the req vector and a start index; outputs are the found flag and the winner index. Fixed mode uses it with a descending scan.

## Test plan
All scenarios use N=2, MAX_HOLD=4.
- Reset: hold reset for 2 cycles with req=4'b1111 -> gnt_valid=0, gnt_idx=0, gnt_onehot=4'b0000, timeout=0 throughout.
- Fixed mode, done release:
  - Stimulus: req=4'b0110 from cycle 0; done=1 in cycle 2.
  - Response: cycle 1 gnt_idx=2, gnt_onehot=4'b0100; cycle 3 gnt_valid=0; cycle 4 re-grants idx 2.
- Timeout:
  - Stimulus: req=4'b1000 held, done=0.
  - Response: gnt_valid=1 in cycles 1-4; cycle 5 gnt_valid=0 with timeout=1; cycle 6 re-grants idx 3.
- Round-robin (ARB_RR_EN), wrap-around:
  - Stimulus: req=4'b1111 held; done pulsed in every grant cycle.
  - Response: grant sequence 0,1,2,3,0, with one IDLE cycle between grants.
- Dropped request:
  - Stimulus: owner 1 with req=4'b0010, then req=4'b0000 in grant cycle 2.
  - Response: gnt_valid=0 next cycle, timeout=0; done and timeout coinciding also gives timeout=0.
- Reset mid-grant (round-robin):
  - Stimulus: owner 2 held; reset pulsed for 1 cycle with req=4'b1111.
  - Response: outputs go to 0 after reset; the next grant is idx 0 (ptr restored).
